if_stage: RTL and testbench

Instruction-fetch stage of the RV32I core. It holds the PC, drives the instruction-memory request handshake, and registers the fetched word plus its PC into the IF/ID pipeline register. That register feeds decode and the immediate extender. The stage consumes the extended offset and pcsource resolved downstream to compute branch, JAL and JALR targets, and flushes wrong-path fetches.

---
 rtl/if_stage_if.sv | 48 ++++
 rtl/if_stage.sv | 218 +++++++++++++++++++++
 tb/tb_if_stage.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
//   Signal bundle around the RV32I instruction-fetch stage.
//   Groups three things:
//     - the instruction-memory request handshake (imem_*)
//     - the redirect inputs resolved downstream (redirect_*, pcsource,
//       offset, rs1_value)
//     - the IF/ID pipeline register outputs (id_*) and misalign_err
//   Modports:
//     master : the fetch stage view (drives imem_req/addr, id_*, misalign_err)
//     slave  : the environment view (memory + decode + resolve logic)
// ---------------------------------------------------------------------------
interface if_stage_if;
  // Instruction-memory handshake
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  // Decode back-pressure and control-transfer resolution
  logic        id_stall;
  logic        redirect_valid;
  logic [1:0]  pcsource;
  logic [31:0] redirect_pc;
  logic [31:0] offset;
  logic [31:0] rs1_value;

  // IF/ID pipeline register
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    input  id_stall, redirect_valid, pcsource, redirect_pc, offset, rs1_value,
    output id_valid, id_inst, id_pc, id_pc4, misalign_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    output id_stall, redirect_valid, pcsource, redirect_pc, offset, rs1_value,
    input  id_valid, id_inst, id_pc, id_pc4, misalign_err
  );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage of the RV32I core. Holds the PC, issues fetch
//   requests to instruction memory, and registers the fetched word with its
//   PC into the IF/ID pipeline register. Redirects (branch / jal / jalr)
//   resolved downstream flush wrong-path work and retarget the PC.
//
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : if_stage_if.master
//            imem_req/imem_addr out, imem_ready/imem_rdata in
//            id_stall, redirect_valid, pcsource, redirect_pc, offset,
//            rs1_value in
//            id_valid, id_inst, id_pc, id_pc4, misalign_err out
//
//   States:
//     IDLE : one cycle after reset release
//     REQ  : request outstanding at imem_addr = pc
//     HELD : fetched word parked in the skid buffer while decode stalls
//     DROP : wrong-path request still outstanding; wait for it, discard data
//     HALT : misaligned redirect target; fetch stopped until reset
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    HELD = 3'd2,
    DROP = 3'd3,
    HALT = 3'd4
  } state_e;

  localparam logic [1:0] PCS_SEQ    = 2'b00;
  localparam logic [1:0] PCS_JALR   = 2'b10;

  // State and datapath registers
  state_e      state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;  // address of the abandoned request
  logic        id_valid_q,  id_valid_d;
  logic [31:0] id_inst_q,   id_inst_d;
  logic [31:0] id_pc_q,     id_pc_d;
  logic [31:0] id_pc4_q,    id_pc4_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q,  buf_inst_d;
  logic [31:0] buf_pc_q,    buf_pc_d;
  logic        misalign_q,  misalign_d;

  // Redirect target computation
  logic [31:0] tgt_base;
  logic [31:0] tgt_sum;
  logic [31:0] target;
  logic        redirect;
  logic        tgt_misaligned;
  logic        id_hold;

  always_comb begin
    tgt_base = (bus.pcsource == PCS_JALR) ? bus.rs1_value : bus.redirect_pc;
    // Modulo-2^32 add; wrap-around is a legal target, not an error.
    tgt_sum  = tgt_base + bus.offset;
    // jalr clears bit 0 before the alignment check.
    target   = (bus.pcsource == PCS_JALR) ? (tgt_sum & ~32'h1) : tgt_sum;
    tgt_misaligned = (target[1:0] != 2'b00);
    // A halted stage ignores everything until reset.
    redirect = bus.redirect_valid && (bus.pcsource != PCS_SEQ) && (state_q != HALT);
    // Decode holds the IF/ID slot only when it actually contains something.
    id_hold  = id_valid_q && bus.id_stall;
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; always_comb uses blocking (=) with a default for every
  // signal first, so no path leaves a variable unassigned and infers a latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      id_valid_q  <= 1'b0;
      id_inst_q   <= NOP_INST;
      id_pc_q     <= 32'h0000_0000;
      id_pc4_q    <= 32'h0000_0004;
      buf_valid_q <= 1'b0;
      buf_inst_q  <= NOP_INST;
      buf_pc_q    <= 32'h0000_0000;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      id_valid_q  <= id_valid_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      buf_valid_q <= buf_valid_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc_q    <= buf_pc_d;
      misalign_q  <= misalign_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    id_valid_d  = id_valid_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    misalign_d  = misalign_q;

    // Decode consumes the slot whenever it is not holding it; the slot then
    // reads as empty unless a new word is loaded below this cycle.
    if (!id_hold) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end

    unique case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        if (bus.imem_ready) begin
          pc_d = pc_q + 32'd4;
          if (id_hold) begin
            // Decode is full: park the word so the handshake still completes.
            buf_valid_d = 1'b1;
            buf_inst_d  = bus.imem_rdata;
            buf_pc_d    = pc_q;
            state_d     = HELD;
          end else begin
            id_valid_d = 1'b1;
            id_inst_d  = bus.imem_rdata;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_q + 32'd4;
          end
        end
      end

      HELD: begin
        if (!bus.id_stall) begin
          id_valid_d  = 1'b1;
          id_inst_d   = buf_inst_q;
          id_pc_d     = buf_pc_q;
          id_pc4_d    = buf_pc_q + 32'd4;
          buf_valid_d = 1'b0;
          state_d     = REQ;
        end
      end

      DROP: begin
        // Returned data belongs to the wrong path and is never captured.
        if (bus.imem_ready) state_d = REQ;
      end

      HALT: id_valid_d = 1'b0;

      default: state_d = IDLE;
    endcase

    // Redirect overrides stall and any sequential update above.
    if (redirect) begin
      id_valid_d  = 1'b0;
      id_inst_d   = NOP_INST;
      buf_valid_d = 1'b0;
      pc_d        = target;
      if (tgt_misaligned) begin
        misalign_d = 1'b1;
        state_d    = HALT;
      end else begin
        unique case (state_q)
          REQ: begin
            if (bus.imem_ready) begin
              state_d = REQ;
            end else begin
              // Request cannot be withdrawn: keep the old address on the bus.
              drop_addr_d = pc_q;
              state_d     = DROP;
            end
          end
          HELD:    state_d = REQ;
          DROP:    state_d = bus.imem_ready ? REQ : DROP;
          default: state_d = REQ;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    bus.imem_req  = (state_q == REQ) || (state_q == DROP);
    bus.imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
    bus.id_valid     = id_valid_q;
    bus.id_inst      = id_inst_q;
    bus.id_pc        = id_pc_q;
    bus.id_pc4       = id_pc4_q;
    bus.misalign_err = misalign_q;
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//   Directed test of the fetch stage. Memory returns mem[a] = a. Inputs are
//   changed 1 ns after a rising edge and outputs are sampled at that same
//   point, so every check sees the state registered by the preceding edge.
// ---------------------------------------------------------------------------
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: mem[a] = a.
  assign bus.imem_rdata = bus.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the IF/ID register in one call.
  task automatic check_id(input string tag, input logic v, input logic [31:0] inst,
                          input logic [31:0] pc);
    check({tag, ".id_valid"}, 32'(bus.id_valid), 32'(v));
    check({tag, ".id_inst"},  bus.id_inst, inst);
    check({tag, ".id_pc"},    bus.id_pc,   pc);
    check({tag, ".id_pc4"},   bus.id_pc4,  pc + 32'd4);
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".imem_req"},  32'(bus.imem_req), 32'(req));
    check({tag, ".imem_addr"}, bus.imem_addr, addr);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.imem_ready     = 1'b1;
    bus.id_stall       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.pcsource       = 2'b00;
    bus.redirect_pc    = 32'h0;
    bus.offset         = 32'h0;
    bus.rs1_value      = 32'h0;

    // Reset state
    tick();
    check_req("reset", 1'b0, 32'h0);
    check_id("reset", 1'b0, NOP, 32'h0);
    check("reset.misalign", 32'(bus.misalign_err), 32'h0);
    rst = 1'b0;

    // IDLE -> REQ
    tick();
    check_req("idle_exit", 1'b1, 32'h0);
    check("idle_exit.id_valid", 32'(bus.id_valid), 32'h0);

    // Zero-wait back-to-back fetch
    tick();
    check_req("fetch0", 1'b1, 32'h4);
    check_id("fetch0", 1'b1, 32'h0, 32'h0);
    tick();
    check_req("fetch4", 1'b1, 32'h8);
    check_id("fetch4", 1'b1, 32'h4, 32'h4);

    // imem_ready low for 3 cycles at address 8
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_req("wait8", 1'b1, 32'h8);
      check("wait8.id_valid", 32'(bus.id_valid), 32'h0);
    end
    bus.imem_ready = 1'b1;
    tick();
    check_req("fetch8", 1'b1, 32'hC);
    check_id("fetch8", 1'b1, 32'h8, 32'h8);

    // Stall while a fetch returns: word 0xC parked, IF/ID held
    bus.id_stall = 1'b1;
    tick();
    check("held1.imem_req", 32'(bus.imem_req), 32'h0);
    check_id("held1", 1'b1, 32'h8, 32'h8);
    tick();
    check("held2.imem_req", 32'(bus.imem_req), 32'h0);
    check_id("held2", 1'b1, 32'h8, 32'h8);
    bus.id_stall = 1'b0;
    tick();
    check_req("unheld", 1'b1, 32'h10);
    check_id("unheld", 1'b1, 32'hC, 32'hC);
    tick();
    check_req("fetch10", 1'b1, 32'h14);
    check_id("fetch10", 1'b1, 32'h10, 32'h10);

    // Branch while a fetch is outstanding: 0x10 + -8 = 0x08
    bus.imem_ready = 1'b0;
    tick();
    check_req("pend14", 1'b1, 32'h14);
    check("pend14.id_valid", 32'(bus.id_valid), 32'h0);
    bus.redirect_valid = 1'b1;
    bus.pcsource       = 2'b01;
    bus.redirect_pc    = 32'h0000_0010;
    bus.offset         = 32'hFFFF_FFF8;
    tick();
    check_req("drop1", 1'b1, 32'h14);
    check("drop1.id_valid", 32'(bus.id_valid), 32'h0);
    bus.redirect_valid = 1'b0;
    tick();
    check_req("drop2", 1'b1, 32'h14);
    bus.imem_ready = 1'b1;
    tick();
    check_req("flush", 1'b1, 32'h8);
    check_id("flush", 1'b0, NOP, 32'h10);
    tick();
    check_req("btarget", 1'b1, 32'hC);
    check_id("btarget", 1'b1, 32'h8, 32'h8);

    // jalr (0x101 + 3) & ~1 = 0x104, overriding a stall on a full slot
    bus.id_stall       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.pcsource       = 2'b10;
    bus.rs1_value      = 32'h0000_0101;
    bus.offset         = 32'h0000_0003;
    tick();
    check_req("jalr", 1'b1, 32'h104);
    check("jalr.id_valid", 32'(bus.id_valid), 32'h0);
    check("jalr.id_inst", bus.id_inst, NOP);

    // jal 0xFFFFFFFC + 8 wraps to 0x4
    bus.pcsource    = 2'b11;
    bus.redirect_pc = 32'hFFFF_FFFC;
    bus.offset      = 32'h0000_0008;
    tick();
    check_req("jal_wrap", 1'b1, 32'h4);
    check("jal_wrap.id_valid", 32'(bus.id_valid), 32'h0);

    // Stall with an empty slot is ignored
    bus.redirect_valid = 1'b0;
    tick();
    check_req("stall_empty", 1'b1, 32'h8);
    check_id("stall_empty", 1'b1, 32'h4, 32'h4);

    // redirect_valid with pcsource=00 is ignored
    bus.id_stall       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.pcsource       = 2'b00;
    bus.redirect_pc    = 32'h40;
    bus.offset         = 32'h40;
    tick();
    check_req("seq_ignored", 1'b1, 32'hC);
    check_id("seq_ignored", 1'b1, 32'h8, 32'h8);

    // Misaligned jalr target 0x102 -> HALT
    bus.pcsource  = 2'b10;
    bus.rs1_value = 32'h0000_0102;
    bus.offset    = 32'h0;
    tick();
    check("halt.misalign", 32'(bus.misalign_err), 32'h1);
    check("halt.imem_req", 32'(bus.imem_req), 32'h0);
    check("halt.id_valid", 32'(bus.id_valid), 32'h0);
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    check("halt2.misalign", 32'(bus.misalign_err), 32'h1);
    check("halt2.imem_req", 32'(bus.imem_req), 32'h0);

    // Asynchronous reset mid-HALT
    rst = 1'b1;
    #1;
    check_req("rst_halt", 1'b0, 32'h0);
    check_id("rst_halt", 1'b0, NOP, 32'h0);
    check("rst_halt.misalign", 32'(bus.misalign_err), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check_req("restart", 1'b1, 32'h0);
    tick();
    check_req("restart_fetch", 1'b1, 32'h4);
    check_id("restart_fetch", 1'b1, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
